// File: rtl/riscv_dmem_mmio_if.sv
// Data-port bundle between the core's M stage and the data-side responder.
interface riscv_dmem_mmio_if;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;

  modport master (
    output MemWriteM,
    output ALUResultM,
    output WriteDataM,
    input  ReadDataM
  );

  modport slave (
    input  MemWriteM,
    input  ALUResultM,
    input  WriteDataM,
    output ReadDataM
  );
endinterface

// File: rtl/riscv_dmem_mmio.sv
// riscv_dmem_mmio: data-side responder for the pipelined RV32 core.
// Word RAM at addr[31]==0. The MMIO page at 0x800000xx holds LED, CYCLE, TXDATA and STATUS.
// Loads are combinational (zero latency). Stores commit on the rising clock edge.
// Optional UART TX (8N1) is enabled with the macro RISCV_DMEM_UART_EN. Without it,
// uart_tx is tied high, and TXDATA/STATUS read as zero and ignore writes.
module riscv_dmem_mmio #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned CLK_DIV = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  riscv_dmem_mmio_if.slave     bus,
  output logic [7:0]           led,
  output logic                 uart_tx
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0]   addr;
  logic          we;
  logic          ram_hit;
  logic          mmio_hit;
  logic [5:0]    reg_sel;
  logic [AW-1:0] idx;
  logic          led_wr;
  logic          cyc_wr;
  logic [31:0]   cycle;
  logic [31:0]   status_rd;
  logic [31:0]   mem [DEPTH];
  logic          unused_addr_bits;

  assign addr             = bus.ALUResultM;
  assign we               = bus.MemWriteM;
  assign ram_hit          = ~addr[31];
  assign mmio_hit         = (addr[31:8] == 24'h800000);
  assign reg_sel          = addr[7:2];
  assign idx              = addr[AW+1:2];
  assign led_wr           = we && mmio_hit && (reg_sel == 6'd0);
  assign cyc_wr           = we && mmio_hit && (reg_sel == 6'd1);
  assign unused_addr_bits = ^addr[1:0];

  // Word RAM: written on a RAM hit; not reset.
  always_ff @(posedge clk) begin
    if (we && ram_hit)
      mem[idx] <= bus.WriteDataM;
  end

  // LED register and free-running cycle counter. A write to CYCLE replaces the increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led   <= '0;
      cycle <= '0;
    end else begin
      if (led_wr)
        led <= bus.WriteDataM[7:0];
      if (cyc_wr)
        cycle <= bus.WriteDataM;
      else
        cycle <= cycle + 32'd1;
    end
  end

`ifdef RISCV_DMEM_UART_EN
  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } uart_state_t;

  uart_state_t   state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_nxt;
  logic [7:0]    shreg;
  logic          overrun;
  logic          tx_q;
  logic          tx_wr;
  logic          status_wr;
  logic          accept;
  logic          drop;
  logic          busy;

  assign tx_wr     = we && mmio_hit && (reg_sel == 6'd2);
  assign status_wr = we && mmio_hit && (reg_sel == 6'd3);
  assign accept    = tx_wr && (state == S_IDLE);
  assign drop      = tx_wr && (state != S_IDLE);
  assign busy      = (state != S_IDLE) || accept;
  assign bit_nxt   = bit_idx + 3'd1;
  assign status_rd = {30'd0, overrun, busy};
  assign uart_tx   = tx_q;

  // UART TX FSM. The line level is registered and is updated together with each state
  // transition, so it changes exactly on bit-period boundaries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
      overrun <= 1'b0;
    end else begin
      if (drop)
        overrun <= 1'b1;
      else if (status_wr)
        overrun <= 1'b0;

      case (state)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (accept) begin
            shreg <= bus.WriteDataM[7:0];
            state <= S_START;
            cnt   <= '0;
            tx_q  <= 1'b0;
          end
        end
        S_START: begin
          if (cnt == CNT_LAST) begin
            state   <= S_DATA;
            cnt     <= '0;
            bit_idx <= '0;
            tx_q    <= shreg[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
              tx_q  <= 1'b1;
            end else begin
              bit_idx <= bit_nxt;
              tx_q    <= shreg[bit_nxt];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == CNT_LAST) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end
`else
  assign status_rd = '0;
  assign uart_tx   = 1'b1;
`endif

  // Combinational load data. Unmapped addresses and TXDATA read as zero.
  always_comb begin
    bus.ReadDataM = '0;
    if (ram_hit) begin
      bus.ReadDataM = mem[idx];
    end else if (mmio_hit) begin
      case (reg_sel)
        6'd0:    bus.ReadDataM = {24'd0, led};
        6'd1:    bus.ReadDataM = cycle;
        6'd3:    bus.ReadDataM = status_rd;
        default: bus.ReadDataM = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_dmem_mmio.sv
// Directed testbench for riscv_dmem_mmio (DEPTH=64, CLK_DIV=4).
// UART expectations follow RISCV_DMEM_UART_EN.
module tb_riscv_dmem_mmio;

  localparam logic [31:0] A_LED  = 32'h8000_0000;
  localparam logic [31:0] A_CYC  = 32'h8000_0004;
  localparam logic [31:0] A_TXD  = 32'h8000_0008;
  localparam logic [31:0] A_STAT = 32'h8000_000C;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] led;
  logic       uart_tx;

  int checks   = 0;
  int failures = 0;

  riscv_dmem_mmio_if bus ();

  riscv_dmem_mmio #(.DEPTH(64), .CLK_DIV(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .led     (led),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  function automatic vec_t mk(logic we, logic [31:0] addr, logic [31:0] wdata,
                              logic chk, logic [31:0] exp);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.chk = chk; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.MemWriteM  = w;
    bus.ALUResultM = a;
    bus.WriteDataM = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vt [19];

  logic [7:0]  txbyte;
  logic [31:0] exp_stat;
  logic        exp_tx;
  logic        ovr;

  initial begin
    vt[0]  = mk(1, 32'h0000_0000, 32'h1111_1111, 0, 32'h0);
    vt[1]  = mk(1, 32'h0000_0010, 32'h1234_5678, 0, 32'h0);
    vt[2]  = mk(0, 32'h0000_0010, 32'h0,         1, 32'h1234_5678);
    vt[3]  = mk(0, 32'h0000_0110, 32'h0,         1, 32'h1234_5678);
    vt[4]  = mk(0, 32'h0000_0013, 32'h0,         1, 32'h1234_5678);
    vt[5]  = mk(1, 32'h0000_0010, 32'hCAFE_F00D, 1, 32'h1234_5678);
    vt[6]  = mk(0, 32'h0000_0010, 32'h0,         1, 32'hCAFE_F00D);
    vt[7]  = mk(1, 32'h0000_00FC, 32'h0BAD_CAFE, 0, 32'h0);
    vt[8]  = mk(0, 32'h0000_01FC, 32'h0,         1, 32'h0BAD_CAFE);
    vt[9]  = mk(1, A_LED,         32'h0000_01A5, 0, 32'h0);
    vt[10] = mk(0, A_LED,         32'h0,         1, 32'h0000_00A5);
    vt[11] = mk(1, 32'h9000_0000, 32'hFFFF_FFFF, 1, 32'h0);
    vt[12] = mk(1, 32'h8000_0100, 32'hFFFF_FFFF, 1, 32'h0);
    vt[13] = mk(0, 32'h0000_0000, 32'h0,         1, 32'h1111_1111);
    vt[14] = mk(0, A_LED,         32'h0,         1, 32'h0000_00A5);
    vt[15] = mk(0, A_TXD,         32'h0,         1, 32'h0);
    vt[16] = mk(0, 32'h8000_0010, 32'h0,         1, 32'h0);
    vt[17] = mk(0, 32'h9000_0000, 32'h0,         1, 32'h0);
    vt[18] = mk(0, A_STAT,        32'h0,         1, 32'h0);

    // Reset state
    reset = 1'b0;
    drive(0, A_CYC, 32'h0);
    #12;
    check("rst_led", {24'd0, led}, 32'h0);
    check("rst_uart_tx", {31'd0, uart_tx}, 32'h1);
    check("rst_cycle", bus.ReadDataM, 32'h0);
    bus.ALUResultM = A_STAT;
    #1;
    check("rst_status", bus.ReadDataM, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Table-driven RAM / LED / decode vectors
    for (int i = 0; i < 19; i++) begin
      drive(vt[i].we, vt[i].addr, vt[i].wdata);
      #1;
      if (vt[i].chk)
        check($sformatf("vec%0d_rd", i), bus.ReadDataM, vt[i].exp);
      tick();
    end
    drive(0, 32'h0, 32'h0);
    check("led_out", {24'd0, led}, 32'h0000_00A5);

    // Asynchronous reset clears LED without a clock edge
    #2 reset = 1'b0;
    #1;
    check("led_async_rst", {24'd0, led}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // CYCLE write and wrap
    drive(1, A_CYC, 32'hFFFF_FFFE);
    tick();
    drive(0, A_CYC, 32'h0);
    #1;
    check("cyc_wr", bus.ReadDataM, 32'hFFFF_FFFE);
    tick();
    check("cyc_inc", bus.ReadDataM, 32'hFFFF_FFFF);
    tick();
    check("cyc_wrap", bus.ReadDataM, 32'h0);

`ifdef RISCV_DMEM_UART_EN
    // Frame for 0x55 with a dropped 0xAA write and a STATUS clear mid-frame
    txbyte = 8'h55;
    ovr    = 1'b0;
    drive(1, A_TXD, 32'h0000_0055);
    tick();
    for (int i = 0; i < 40; i++) begin
      if (i < 4)       exp_tx = 1'b0;
      else if (i < 36) exp_tx = txbyte[(i / 4) - 1];
      else             exp_tx = 1'b1;
      check($sformatf("frame_tx%0d", i), {31'd0, uart_tx}, {31'd0, exp_tx});
      if (i == 10) begin
        drive(1, A_TXD, 32'h0000_00AA);
        ovr = 1'b1;
      end else if (i == 20) begin
        drive(1, A_STAT, 32'h1234_5678);
        ovr = 1'b0;
      end else begin
        drive(0, A_STAT, 32'h0);
        #1;
        exp_stat = {30'd0, ovr, 1'b1};
        check($sformatf("frame_stat%0d", i), bus.ReadDataM, exp_stat);
      end
      tick();
    end
    drive(0, A_STAT, 32'h0);
    #1;
    check("frame_done_stat", bus.ReadDataM, 32'h0);
    check("frame_done_tx", {31'd0, uart_tx}, 32'h1);

    // Reset during the DATA phase abandons the frame
    drive(1, A_TXD, 32'h0000_0000);
    tick();
    drive(0, A_STAT, 32'h0);
    for (int i = 0; i < 6; i++) tick();
    check("mid_data_tx", {31'd0, uart_tx}, 32'h0);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_tx", {31'd0, uart_tx}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("post_rst_stat", bus.ReadDataM, 32'h0);
    check("post_rst_tx", {31'd0, uart_tx}, 32'h1);
`else
    // Without the UART, TXDATA/STATUS writes have no effect and the line stays idle
    drive(1, A_TXD, 32'h0000_0055);
    tick();
    drive(1, A_STAT, 32'hFFFF_FFFF);
    tick();
    drive(0, A_STAT, 32'h0);
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("nouart_stat%0d", i), bus.ReadDataM, 32'h0);
      check($sformatf("nouart_tx%0d", i), {31'd0, uart_tx}, 32'h1);
      tick();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
